// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package arm_mem_pkg;

  localparam int MEM_W = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memarb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory port.
// MEMARB_RR_EN selects round-robin; otherwise the core has fixed priority.
module mem_arb_pick
  import arm_mem_pkg::*;
(
  input  logic core_req,
  input  logic dma_req,
  input  logic last_grant,
  output logic grant
);

`ifdef MEMARB_RR_EN
  always_comb begin
    grant = PORT_CORE;
    if (core_req && dma_req) begin
      grant = (last_grant == PORT_CORE) ? PORT_DMA : PORT_CORE;
    end else if (dma_req) begin
      grant = PORT_DMA;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = PORT_CORE;
    if (dma_req && !core_req) begin
      grant = PORT_DMA;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the core and a DMA/loader master.
// MEMARB_RR_EN enables round-robin arbitration (default build: core priority).
//
// Handshake: a requester raises req with we/adr/wdata stable and keeps them
// until its rdy pulses for one cycle; rdata is valid with rdy and held until
// that port's next completion. Requests are only sampled in IDLE.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [MEM_W-1:0] core_adr,
  input  logic [MEM_W-1:0] core_wdata,
  output logic             core_rdy,
  output logic [MEM_W-1:0] core_rdata,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [MEM_W-1:0] dma_adr,
  input  logic [MEM_W-1:0] dma_wdata,
  output logic             dma_rdy,
  output logic [MEM_W-1:0] dma_rdata,
  output logic             MemWrite,
  output logic [MEM_W-1:0] Adr,
  output logic [MEM_W-1:0] WriteData,
  input  logic [MEM_W-1:0] ReadData,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  memarb_state_t    state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic             lat_port;
  logic             any_req;
  logic             grant;
  logic             last_grant;

  assign any_req = core_req || dma_req;

  mem_arb_pick u_pick (
    .core_req   (core_req),
    .dma_req    (dma_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

`ifdef MEMARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= PORT_DMA;
    end else if (state == IDLE && any_req) begin
      last_grant <= grant;
    end
  end
`else
  assign last_grant = PORT_DMA;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The write strobe fires only while cnt still holds its load value,
  // i.e. in the first ACCESS cycle, so each write hits memory exactly once.
  always_comb begin
    MemWrite  = (state == ACCESS) && lat_we && (cnt == CNT_LOAD);
    core_rdy  = (state == DONE) && (lat_port == PORT_CORE);
    dma_rdy   = (state == DONE) && (lat_port == PORT_DMA);
    dbg_state = state;
  end

  // Adr/WriteData are the latched request fields, so they hold between accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_port   <= PORT_CORE;
      Adr        <= '0;
      WriteData  <= '0;
      core_rdata <= '0;
      dma_rdata  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        lat_port  <= grant;
        lat_we    <= (grant == PORT_CORE) ? core_we : dma_we;
        Adr       <= (grant == PORT_CORE) ? core_adr : dma_adr;
        WriteData <= (grant == PORT_CORE) ? core_wdata : dma_wdata;
        cnt       <= CNT_LOAD;
      end else if (state == ACCESS) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else if (!lat_we) begin
          if (lat_port == PORT_CORE) begin
            core_rdata <= ReadData;
          end else begin
            dma_rdata <= ReadData;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction-timing reference model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
`ifdef MEMARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        core_req, core_we, dma_req, dma_we;
  logic [31:0] core_adr, core_wdata, dma_adr, dma_wdata;
  logic        core_rdy, dma_rdy, MemWrite;
  logic [31:0] core_rdata, dma_rdata, Adr, WriteData, ReadData;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_adr   (core_adr),
    .core_wdata (core_wdata),
    .core_rdy   (core_rdy),
    .core_rdata (core_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_adr    (dma_adr),
    .dma_wdata  (dma_wdata),
    .dma_rdy    (dma_rdy),
    .dma_rdata  (dma_rdata),
    .MemWrite   (MemWrite),
    .Adr        (Adr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .dbg_state  (dbg_state)
  );

  // memory seen by the DUT, and the model's own copy
  logic [31:0] mem_dut [0:63];
  logic [31:0] ref_mem [0:63];
  assign ReadData = mem_dut[Adr[7:2]];

  int n_checks = 0;
  int n_errors = 0;

  // reference model: an accepted access at edge s occupies the port for
  // LAT cycles, completes at edge s+LAT and frees the arbiter at s+LAT+1
  int          e;
  int          m_start;
  logic        m_busy, m_last, m_port, m_we;
  logic [31:0] m_adr, m_wd;
  logic [31:0] m_rd [0:1];
  logic        exp_mw, exp_crdy, exp_drdy;

  // scoreboard of expected completing port (0 core, 1 dma)
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0;
    m_adr = '0; m_wd = '0; m_rd[0] = '0; m_rd[1] = '0; m_start = 0;
  endtask

  task automatic model_edge();
    e++;
    if (!reset) begin
      model_reset();
    end else if (!m_busy) begin
      if (core_req || dma_req) begin
        if (core_req && dma_req) m_port = RR_EN ? !m_last : 1'b0;
        else                     m_port = dma_req;
        m_last  = m_port;
        m_busy  = 1'b1;
        m_start = e;
        m_we    = m_port ? dma_we : core_we;
        m_adr   = m_port ? dma_adr : core_adr;
        m_wd    = m_port ? dma_wdata : core_wdata;
      end
    end else begin
      if (m_we && e == m_start + 1) ref_mem[m_adr[7:2]] = m_wd;
      if (!m_we && e == m_start + LAT) m_rd[m_port] = ref_mem[m_adr[7:2]];
      if (e == m_start + LAT + 1) m_busy = 1'b0;
    end
    exp_mw   = m_busy && m_we && (e == m_start);
    exp_crdy = m_busy && (e == m_start + LAT) && !m_port;
    exp_drdy = m_busy && (e == m_start + LAT) && m_port;
  endtask

  // one clock: emulate memory, advance model, compare at the falling edge
  task automatic cycle();
    logic        mw;
    logic [31:0] a, wd;
    mw = MemWrite; a = Adr; wd = WriteData;
    @(posedge clk);
    #1;
    if (mw) mem_dut[a[7:2]] = wd;
    model_edge();
    @(negedge clk);
    check("memwrite",   32'(MemWrite),  32'(exp_mw));
    check("adr",        Adr,            m_adr);
    check("writedata",  WriteData,      m_wd);
    check("core_rdy",   32'(core_rdy),  32'(exp_crdy));
    check("dma_rdy",    32'(dma_rdy),   32'(exp_drdy));
    check("core_rdata", core_rdata,     m_rd[0]);
    check("dma_rdata",  dma_rdata,      m_rd[1]);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_memwrite"},   32'(MemWrite),  32'd0);
    check({tag, "_adr"},        Adr,            32'd0);
    check({tag, "_writedata"},  WriteData,      32'd0);
    check({tag, "_core_rdy"},   32'(core_rdy),  32'd0);
    check({tag, "_dma_rdy"},    32'(dma_rdy),   32'd0);
    check({tag, "_core_rdata"}, core_rdata,     32'd0);
    check({tag, "_dma_rdata"},  dma_rdata,      32'd0);
    check({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic completion_order(input string tag);
    logic [31:0] want;
    if (core_rdy || dma_rdy) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_rdy"}, 32'(dma_rdy), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check({tag, "_order"}, 32'(dma_rdy), want);
      end
    end
  endtask

  task automatic drive_random();
    if (core_req && core_rdy) core_req = 1'b0;
    if (dma_req && dma_rdy) dma_req = 1'b0;
    if (!core_req && $urandom_range(0, 2) == 0) begin
      core_req   = 1'b1;
      core_we    = 1'($urandom_range(0, 1));
      core_adr   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      core_wdata = $urandom;
    end
    if (!dma_req && $urandom_range(0, 2) == 0) begin
      dma_req   = 1'b1;
      dma_we    = 1'($urandom_range(0, 1));
      dma_adr   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      dma_wdata = $urandom;
    end
  endtask

  initial begin
    int          n, mw_cnt, rdy_cnt, t_first, t_second;
    logic        got;
    logic [31:0] a_seen, wd_seen, v;

    for (int i = 0; i < 64; i++) begin
      mem_dut[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
      ref_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    end
    core_req = 0; core_we = 0; core_adr = '0; core_wdata = '0;
    dma_req = 0; dma_we = 0; dma_adr = '0; dma_wdata = '0;
    e = 0;
    model_reset();

    reset = 1'b0;
    #1;
    reset_checks("rst0");
    cycle();
    cycle();
    reset = 1'b1;
    cycle();

    // core read alone
    mem_dut[8] = 32'hE3A0_1005;
    ref_mem[8] = 32'hE3A0_1005;
    core_req = 1; core_we = 0; core_adr = 32'h20;
    n = 0; mw_cnt = 0; got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      cycle();
      if (MemWrite) mw_cnt++;
      if (core_rdy) begin got = 1; n = k; end
    end
    check("t1_latency", 32'(n), 32'(LAT + 1));
    check("t1_rdata", core_rdata, 32'hE3A0_1005);
    check("t1_no_memwrite", 32'(mw_cnt), 32'd0);
    core_req = 0;
    cycle();

    // dma write alone
    dma_req = 1; dma_we = 1; dma_adr = 32'h40; dma_wdata = 32'hDEAD_BEEF;
    mw_cnt = 0; rdy_cnt = 0; a_seen = '0; wd_seen = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (MemWrite) begin mw_cnt++; a_seen = Adr; wd_seen = WriteData; end
      if (dma_rdy) begin rdy_cnt++; dma_req = 0; end
    end
    check("t2_strobes", 32'(mw_cnt), 32'd1);
    check("t2_strobe_adr", a_seen, 32'h40);
    check("t2_strobe_data", wd_seen, 32'hDEAD_BEEF);
    check("t2_rdy_pulses", 32'(rdy_cnt), 32'd1);
    check("t2_mem", mem_dut[16], 32'hDEAD_BEEF);

    // continuous contention
    core_req = 1; core_we = 0; core_adr = 32'h10;
    dma_req = 1; dma_we = 0; dma_adr = 32'h14;
    for (int i = 0; i < 6; i++) exp_q.push_back(RR_EN ? 32'(i % 2) : 32'd0);
    for (int k = 0; k < 6 * (LAT + 2); k++) begin
      cycle();
      completion_order("t3");
    end
    check("t3_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    core_req = 0; dma_req = 0;
    cycle();
    cycle();

    // core drops req after grant; dma arrives during the access
    core_req = 1; core_we = 0; core_adr = 32'h24;
    cycle();
    core_req = 0;
    dma_req = 1; dma_we = 0; dma_adr = 32'h44;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    for (int k = 0; k < 2 * (LAT + 2) + 2; k++) begin
      cycle();
      completion_order("t4");
      if (dma_rdy) dma_req = 0;
    end
    check("t4_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // reset in the second access cycle of a write
    core_req = 1; core_we = 1; core_adr = 32'h48; core_wdata = $urandom;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    reset_checks("t5");
    core_req = 0;
    cycle();
    cycle();
    reset = 1'b1;
    core_req = 1; core_we = 0; core_adr = 32'h30;
    dma_req = 1; dma_we = 0; dma_adr = 32'h34;
    exp_q.push_back(32'd0);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle();
      completion_order("t5");
      if (core_rdy || dma_rdy) begin got = 1; core_req = 0; dma_req = 0; end
    end
    check("t5_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cycle();

    // back-to-back write then read to the same address
    v = $urandom;
    core_req = 1; core_we = 1; core_adr = 32'h80; core_wdata = v;
    t_first = -1; t_second = -1;
    for (int k = 0; k < 20 && t_second < 0; k++) begin
      cycle();
      if (core_rdy) begin
        if (t_first < 0) begin t_first = k; core_we = 0; end
        else begin t_second = k; core_req = 0; end
      end
    end
    check("t6_gap", 32'(t_second - t_first), 32'(LAT + 2));
    check("t6_readback", core_rdata, v);
    cycle();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single unified instruction/data memory port (MemWrite, Adr, WriteData, ReadData) between the multicycle ARM core and a DMA/loader master. Each access is latched at grant, held on the memory port for a parameterised number of cycles, then completed with a one-cycle ready pulse and registered read data. The core uses its ready signal to stall its FSM.

## Interface
- MEM_LAT, 1, memory access length in cycles (≥1); the address is held stable for this many cycles.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- core_req, dma_req  input  1  access request; must be held with its fields stable until the matching rdy.
- core_we, dma_we  input  1  1 = write, 0 = read.
- core_adr, dma_adr  input  32  byte address.
- core_wdata, dma_wdata  input  32  write data.
- core_rdy, dma_rdy  output  1  one-cycle completion pulse.
- core_rdata, dma_rdata  output  32  registered read data, valid with rdy and held until the next completion on that port.
- MemWrite  output  1  memory write strobe.
- Adr  output  32  memory address.
- WriteData  output  32  memory write data.
- ReadData  input  32  memory read data (combinational from Adr).

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high, pick a winner, latch its we/adr/wdata and the grant index, load cnt = MEM_LAT-1, go to ACCESS. Otherwise stay in IDLE.
- ACCESS: drive Adr/WriteData from the latched fields.
  - MemWrite = latched we, asserted only in the first ACCESS cycle (exactly one strobe per write).
  - Decrement cnt each cycle. When cnt==0, capture ReadData into the granted port's rdata (reads only) and go to DONE.
- DONE: pulse the granted port's rdy for one cycle, then go to IDLE unconditionally. Back-to-back accesses cost MEM_LAT+2 cycles each.
- Winner selection with both requests high: round-robin (see Configuration). With a single request, that request always wins.
- Requester drops req mid-access: the transaction still completes and rdy still pulses; memory state changes as latched.
- Outside ACCESS: Adr and WriteData hold their last values; MemWrite = 0.
- cnt width is $clog2(MEM_LAT+1). MEM_LAT = 0 is illegal and is rejected by an elaboration-time assertion.

## Timing
- Reset values: state IDLE, all rdy 0, MemWrite 0, Adr 0, WriteData 0, both rdata 0, cnt 0, last-grant pointer = dma (so the core wins the first contention).
- Request seen high at edge N (IDLE) → ACCESS from N+1 through N+MEM_LAT → rdy high during cycle N+MEM_LAT+1.
- Arbitration uses req values sampled in IDLE only. A request arriving during ACCESS or DONE waits.
- Reset asserted mid-operation: immediate return to reset values, no rdy pulse, no further MemWrite. The aborted access is not retried.
- The last-grant pointer updates at the IDLE→ACCESS edge.

## Configuration
- MEMARB_RR_EN defined: round-robin arbitration; on contention, the port not granted last wins.
- MEMARB_RR_EN undefined: fixed priority, core always wins contention. The last-grant pointer is not implemented. The DMA can starve, which is accepted for boot-load-only use.

## Structure
- Shared package arm_mem_pkg:
  - memarb_state_t enum (IDLE, ACCESS, DONE).
  - Port index constants PORT_CORE = 0, PORT_DMA = 1.
  - Address/data width constant 32.
- One sub-module, mem_arb_pick: combinational winner selection from {core_req, dma_req, last_grant}. This isolates the macro-dependent logic.

## Test plan
- Core read alone, MEM_LAT=2, adr 0x20, memory returns 0xE3A0_1005 → core_rdy high exactly 3 cycles after the IDLE sample edge, core_rdata = 0xE3A0_1005, MemWrite never high.
- DMA write alone, adr 0x40, wdata 0xDEAD_BEEF → MemWrite high for exactly one cycle with Adr = 0x40, WriteData = 0xDEAD_BEEF; dma_rdy pulses once.
- Both requests held high continuously, MEMARB_RR_EN defined → grants alternate core, dma, core, dma. Undefined → core only; dma_rdy never pulses while core_req stays high.
- Core drops req one cycle into a MEM_LAT=3 read → access completes, core_rdy still pulses, next IDLE serves dma.
- Reset asserted during the second ACCESS cycle of a write → all outputs return to reset values the same cycle, no rdy. After release, the first contention grants the core.
- Core write then core read to 0x80 back-to-back, MEM_LAT=1 → read returns the written value; the two rdy pulses are 3 cycles apart.
